// File: rtl/soc_system_pwm_clkgen.sv
// Multi-channel NCO timebase: per-channel phase accumulator giving a wrap tick and a square wave.
// Optional PWM_CLKGEN_PHASE_EN: reconfiguration preloads the accumulator with cfg_phase instead of zero.
module soc_system_pwm_clkgen #(
   parameter int NUM_CH = 4,
   parameter int ACC_W = 32,
   parameter int LOCK_CYCLES = 16,
   parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(129295610),
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out,
   output logic              locked
);

   // state  | meaning
   // IDLE   | config accepted, all channels locked
   // APPLY  | one cycle: write latched config into the target channel
   // SETTLE | counting LOCK_CYCLES before declaring lock again
   typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SETTLE} state_t;

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  settle_cnt;
   logic [CH_W-1:0]   ch_q;
   logic [ACC_W-1:0]  inc_q;
   logic [ACC_W-1:0]  load_val;
   logic              apply_hit;
   logic [ACC_W-1:0]  acc     [NUM_CH];
   logic [ACC_W-1:0]  inc_r   [NUM_CH];
   logic [ACC_W:0]    acc_sum [NUM_CH];

`ifdef PWM_CLKGEN_PHASE_EN
   logic [ACC_W-1:0]  phase_q;
   assign load_val = phase_q;
`else
   logic unused_phase;
   assign unused_phase = ^cfg_phase;
   assign load_val = '0;
`endif

   // an out-of-range channel index makes APPLY a no-op that returns straight to IDLE
   assign apply_hit = (state == ST_APPLY) && ({1'b0, ch_q} < (CH_W + 1)'(NUM_CH));

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state      <= ST_SETTLE;
         settle_cnt <= '0;
         locked     <= 1'b0;
         cfg_ready  <= 1'b0;
         ch_q       <= '0;
         inc_q      <= '0;
`ifdef PWM_CLKGEN_PHASE_EN
         phase_q    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid && cfg_ready) begin
                  ch_q      <= cfg_ch;
                  inc_q     <= cfg_inc;
`ifdef PWM_CLKGEN_PHASE_EN
                  phase_q   <= cfg_phase;
`endif
                  cfg_ready <= 1'b0;
                  state     <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (apply_hit) begin
                  locked     <= 1'b0;
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
               end else begin
                  cfg_ready  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == CNT_LAST) begin
                  locked    <= 1'b1;
                  cfg_ready <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            default: state <= ST_SETTLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_sum[i] = {1'b0, acc[i]} + {1'b0, inc_r[i]};
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i]   <= '0;
            inc_r[i] <= DEFAULT_INC;
         end
         tick    <= '0;
         clk_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (apply_hit && (ch_q == CH_W'(i))) begin
               acc[i]     <= load_val;
               inc_r[i]   <= inc_q;
               tick[i]    <= 1'b0;
               clk_out[i] <= load_val[ACC_W-1];
            end else if (ch_en[i]) begin
               acc[i]     <= acc_sum[i][ACC_W-1:0];
               tick[i]    <= acc_sum[i][ACC_W];
               clk_out[i] <= acc_sum[i][ACC_W-1];
            end else begin
               tick[i]    <= 1'b0;
               clk_out[i] <= acc[i][ACC_W-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_soc_system_pwm_clkgen.sv
// Scoreboard bench for soc_system_pwm_clkgen: a reference model pushes expected outputs each
// edge, a negedge checker pops and compares; directed checks cover lock timing, rates and reset.
`timescale 1ns/1ps
module tb_soc_system_pwm_clkgen;

   localparam int NCH  = 3;
   localparam int AW   = 32;
   localparam int LOCK = 16;
   localparam logic [AW-1:0] DINC = 32'd129295610;
   localparam int CW   = 2;

   logic           refclk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [CW-1:0]  cfg_ch = '0;
   logic [AW-1:0]  cfg_inc = '0;
   logic [AW-1:0]  cfg_phase = '0;
   logic [NCH-1:0] ch_en = '1;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] clk_out;
   logic           locked;

   int n_cmp = 0;
   int n_err = 0;

   soc_system_pwm_clkgen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LOCK), .DEFAULT_INC(DINC)) u_dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .ch_en(ch_en),
      .tick(tick), .clk_out(clk_out), .locked(locked)
   );

   always #10 refclk = ~refclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model (0 idle, 1 apply, 2 settle)
   typedef struct packed {
      logic [NCH-1:0] tick;
      logic [NCH-1:0] clk;
      logic           locked;
      logic           ready;
   } exp_t;
   exp_t sb_q[$];

   logic [AW-1:0]  m_acc [NCH];
   logic [AW-1:0]  m_inc [NCH];
   logic [NCH-1:0] m_tick, m_clk;
   logic           m_locked, m_ready;
   int             m_st, m_cnt, m_ch;
   logic [AW-1:0]  m_incl, m_phl;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = '0;
         m_inc[i] = DINC;
      end
      m_tick = '0; m_clk = '0; m_locked = 1'b0; m_ready = 1'b0;
      m_st = 2; m_cnt = 0; m_ch = 0; m_incl = '0; m_phl = '0;
   endtask

   always @(posedge refclk or posedge rst) begin
      if (rst) begin
         model_reset();
         sb_q.delete();
      end else begin
         for (int i = 0; i < NCH; i++) begin
            logic [AW:0] s;
            if (m_st == 1 && m_ch == i) begin
`ifdef PWM_CLKGEN_PHASE_EN
               m_acc[i] = m_phl;
`else
               m_acc[i] = '0;
`endif
               m_inc[i]  = m_incl;
               m_tick[i] = 1'b0;
            end else if (ch_en[i]) begin
               s = 33'(m_acc[i]) + 33'(m_inc[i]);
               m_acc[i]  = s[AW-1:0];
               m_tick[i] = s[AW];
            end else begin
               m_tick[i] = 1'b0;
            end
            m_clk[i] = m_acc[i][AW-1];
         end
         case (m_st)
            0: if (cfg_valid) begin
                  m_ch = int'(cfg_ch); m_incl = cfg_inc; m_phl = cfg_phase;
                  m_st = 1; m_ready = 1'b0;
               end
            1: if (m_ch < NCH) begin
                  m_locked = 1'b0; m_cnt = 0; m_st = 2;
               end else begin
                  m_st = 0; m_ready = 1'b1;
               end
            default: if (m_cnt == LOCK - 1) begin
                  m_st = 0; m_locked = 1'b1; m_ready = 1'b1;
               end else begin
                  m_cnt++;
               end
         endcase
      end
      sb_q.push_back({m_tick, m_clk, m_locked, m_ready});
   end

   always @(negedge refclk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("sb_tick", 64'(tick), 64'(e.tick));
         chk("sb_clk_out", 64'(clk_out), 64'(e.clk));
         chk("sb_locked", 64'(locked), 64'(e.locked));
         chk("sb_cfg_ready", 64'(cfg_ready), 64'(e.ready));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   // returns the number of cycles the request waited for cfg_ready
   task automatic do_cfg(input int ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph,
                         output int waited);
      bit got;
      got = 1'b0;
      waited = 0;
      cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_inc = inc; cfg_phase = ph;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge refclk);
         if (cfg_ready) got = 1'b1;
         else waited++;
      end
      if (!got) chk("cfg_accept_timeout", 64'(0), 64'(1));
      @(posedge refclk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic count_ch(input int ch, input int n, output int t, output int hi);
      t = 0; hi = 0;
      repeat (n) begin
         @(negedge refclk);
         t  += int'(tick[ch]);
         hi += int'(clk_out[ch]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int w, t0, t1, t2, h0, h1, h2;
      logic [AW-1:0] a;
      logic [63:0] e64;

      // 1: reset and lock timing
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(LOCK - 1);
      chk("lock_before", 64'(locked), 64'(0));
      chk("ready_before", 64'(cfg_ready), 64'(0));
      cyc(1);
      chk("lock_at_16", 64'(locked), 64'(1));
      chk("ready_at_16", 64'(cfg_ready), 64'(1));

      // 2: ch0 at a quarter of refclk
      do_cfg(0, 32'h4000_0000, 32'h8000_0000, w);
      chk("cfg0_wait", 64'(w), 64'(0));
      cyc(2);
      count_ch(0, 40, t0, h0);
      chk("ch0_ticks_40", 64'(t0), 64'(10));
      chk("ch0_high_40", 64'(h0), 64'(20));

      // 3: default increment rate over 2^16 cycles, ch1 and ch2 untouched since reset
      @(negedge refclk);
      a = m_acc[1];
      count_ch(1, 65536, t1, h1);
      e64 = (64'(a) + 64'd65536 * 64'(DINC)) >> 32;
      chk("ch1_rate", 64'(t1), e64);
      chk("ch1_rate_range", 64'(t1 >= 1972 && t1 <= 1973), 64'(1));
      #1;

      // 4: second request held through SETTLE, then out-of-range channel
      do_cfg(1, 32'h2000_0000, 32'h0, w);
      do_cfg(2, 32'h1000_0000, 32'h0, w);
      chk("settle_wait", 64'(w), 64'(LOCK + 1));
      do_cfg(3, 32'h0000_0001, 32'h0, w);
      cyc(1);
      chk("oor_locked", 64'(locked), 64'(1));
      chk("oor_ready", 64'(cfg_ready), 64'(1));
      cyc(LOCK + 4);

      // 5: pause ch1 for 10 cycles
      ch_en[1] = 1'b0;
      cyc(1);
      count_ch(1, 10, t1, h1);
      chk("en_off_ticks", 64'(t1), 64'(0));
      chk("en_off_clk_hold", 64'(h1 == 0 || h1 == 10), 64'(1));
      #1;
      ch_en[1] = 1'b1;
      cyc(20);

      // 6: phase preload on ch2, then reset mid-SETTLE restores default increment
      do_cfg(2, 32'h4000_0000, 32'h8000_0000, w);
      cyc(1);
`ifdef PWM_CLKGEN_PHASE_EN
      chk("phase_clk2", 64'(clk_out[2]), 64'(1));
`else
      chk("phase_clk2", 64'(clk_out[2]), 64'(0));
`endif
      chk("apply_tick2", 64'(tick[2]), 64'(0));
      cyc(5);
      chk("mid_settle_locked", 64'(locked), 64'(0));
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      @(negedge refclk);
      a = m_acc[2];
      fork
         count_ch(2, 2000, t2, h2);
         count_ch(0, 2000, t0, h0);
      join
      e64 = (64'(a) + 64'd2000 * 64'(DINC)) >> 32;
      chk("rst_inc2_rate", 64'(t2), e64);
      chk("rst_ch2_eq_ch0", 64'(t2), 64'(t0));
      cyc(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
